scanline_fx: RTL



---
 rtl/scanline_pkg.sv | 15 +
 rtl/scanline_scale.sv | 28 ++
 rtl/scanline_fx.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/scanline_pkg.sv
// scanline_pkg: shared types and constants for the scanline_fx stage.
//   scan_mode_t : darkening amount applied to odd lines
//   PIPE_DEPTH  : input-to-output latency in ce_pix strobes
package scanline_pkg;

  typedef enum logic [1:0] {
    SCAN_OFF,
    SCAN_25,
    SCAN_50,
    SCAN_75
  } scan_mode_t;

  localparam int PIPE_DEPTH = 2;

endpackage

// File: rtl/scanline_scale.sv
// scanline_scale: combinational single-channel 8-bit darkening.
// Ports:
//   c        in   8  channel value
//   mode     in   2  darkening amount (scan_mode_t)
//   en       in   1  apply darkening; when low c passes unchanged
//   c_scaled out  8  result (never overflows, truncating shifts)
module scanline_scale
  import scanline_pkg::*;
(
  input  logic [7:0] c,
  input  scan_mode_t mode,
  input  logic       en,
  output logic [7:0] c_scaled
);

  always_comb begin
    c_scaled = c;
    if (en) begin
      case (mode)
        SCAN_25: c_scaled = c - (c >> 2);
        SCAN_50: c_scaled = c >> 1;
        SCAN_75: c_scaled = c >> 2;
        default: c_scaled = c;
      endcase
    end
  end

endmodule

// File: rtl/scanline_fx.sv
// scanline_fx: CRT scanline emulation after the colour mixer. Odd lines are
// darkened by the frame-latched mode; colour and timing are re-timed through
// a two-strobe pipeline so they stay aligned.
// Ports:
//   clk_vid, reset_n                    clock, async active-low reset
//   ce_pix                              pixel strobe; all state advances only here
//   scan_mode[1:0]                      requested mode, latched on VSync rise
//   R_in/G_in/B_in[7:0]                 pixel colour
//   HSync_in/VSync_in/HBlank_in/VBlank_in  timing, active-high
//   R_out/G_out/B_out[7:0]              processed colour
//   HSync_out/VSync_out/HBlank_out/VBlank_out  timing delayed to match
//   odd_line                            current line parity
// Build option: SCANLINE_FX_BLANK_ZERO_EN forces colour to 0 during blank.
module scanline_fx
  import scanline_pkg::*;
(
  input  logic       clk_vid,
  input  logic       reset_n,
  input  logic       ce_pix,
  input  logic [1:0] scan_mode,
  input  logic [7:0] R_in,
  input  logic [7:0] G_in,
  input  logic [7:0] B_in,
  input  logic       HSync_in,
  input  logic       VSync_in,
  input  logic       HBlank_in,
  input  logic       VBlank_in,
  output logic [7:0] R_out,
  output logic [7:0] G_out,
  output logic [7:0] B_out,
  output logic       HSync_out,
  output logic       VSync_out,
  output logic       HBlank_out,
  output logic       VBlank_out,
  output logic       odd_line
);

  logic       hs_d_q, vs_d_q;
  logic       parity_q, parity_d;
  scan_mode_t mode_q, mode_d;

  // stage 1
  logic [7:0] r_s1_q, g_s1_q, b_s1_q;
  logic       hs_s1_q, vs_s1_q, hb_s1_q, vb_s1_q;
  logic       dim_s1_q, dim_d;
  scan_mode_t mode_s1_q;

  // stage 2 (outputs)
  logic [7:0] r_s2_q, g_s2_q, b_s2_q;
  logic [7:0] r_s2_d, g_s2_d, b_s2_d;
  logic       hs_s2_q, vs_s2_q, hb_s2_q, vb_s2_q;

  logic [7:0] r_scaled, g_scaled, b_scaled;
  logic       hs_rise, vs_rise;

  always_comb begin
    hs_rise  = HSync_in & ~hs_d_q;
    vs_rise  = VSync_in & ~vs_d_q;
    // VSync takes priority so a coincident HSync cannot leave parity odd.
    parity_d = parity_q;
    if (vs_rise)      parity_d = 1'b0;
    else if (hs_rise) parity_d = ~parity_q;
    mode_d   = vs_rise ? scan_mode_t'(scan_mode) : mode_q;
    // Uses pre-update parity/mode so the dimming decision belongs to this pixel.
    dim_d    = parity_q & (mode_q != SCAN_OFF);
  end

  // The mode travels with the pixel so a VSync in flight cannot re-scale it.
  scanline_scale u_scale_r (.c(r_s1_q), .mode(mode_s1_q), .en(dim_s1_q), .c_scaled(r_scaled));
  scanline_scale u_scale_g (.c(g_s1_q), .mode(mode_s1_q), .en(dim_s1_q), .c_scaled(g_scaled));
  scanline_scale u_scale_b (.c(b_s1_q), .mode(mode_s1_q), .en(dim_s1_q), .c_scaled(b_scaled));

  always_comb begin
    r_s2_d = r_scaled;
    g_s2_d = g_scaled;
    b_s2_d = b_scaled;
`ifdef SCANLINE_FX_BLANK_ZERO_EN
    if (hb_s1_q | vb_s1_q) begin
      r_s2_d = 8'd0;
      g_s2_d = 8'd0;
      b_s2_d = 8'd0;
    end
`endif
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      hs_d_q    <= 1'b0;
      vs_d_q    <= 1'b0;
      parity_q  <= 1'b0;
      mode_q    <= SCAN_OFF;
      r_s1_q    <= 8'd0;
      g_s1_q    <= 8'd0;
      b_s1_q    <= 8'd0;
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      hb_s1_q   <= 1'b0;
      vb_s1_q   <= 1'b0;
      dim_s1_q  <= 1'b0;
      mode_s1_q <= SCAN_OFF;
      r_s2_q    <= 8'd0;
      g_s2_q    <= 8'd0;
      b_s2_q    <= 8'd0;
      hs_s2_q   <= 1'b0;
      vs_s2_q   <= 1'b0;
      hb_s2_q   <= 1'b0;
      vb_s2_q   <= 1'b0;
    end else if (ce_pix) begin
      hs_d_q    <= HSync_in;
      vs_d_q    <= VSync_in;
      parity_q  <= parity_d;
      mode_q    <= mode_d;
      r_s1_q    <= R_in;
      g_s1_q    <= G_in;
      b_s1_q    <= B_in;
      hs_s1_q   <= HSync_in;
      vs_s1_q   <= VSync_in;
      hb_s1_q   <= HBlank_in;
      vb_s1_q   <= VBlank_in;
      dim_s1_q  <= dim_d;
      mode_s1_q <= mode_q;
      r_s2_q    <= r_s2_d;
      g_s2_q    <= g_s2_d;
      b_s2_q    <= b_s2_d;
      hs_s2_q   <= hs_s1_q;
      vs_s2_q   <= vs_s1_q;
      hb_s2_q   <= hb_s1_q;
      vb_s2_q   <= vb_s1_q;
    end
  end

  assign R_out      = r_s2_q;
  assign G_out      = g_s2_q;
  assign B_out      = b_s2_q;
  assign HSync_out  = hs_s2_q;
  assign VSync_out  = vs_s2_q;
  assign HBlank_out = hb_s2_q;
  assign VBlank_out = vb_s2_q;
  assign odd_line   = parity_q;

endmodule
